// File: rtl/ks_pkg.sv
// Shared types and elaboration helpers for the pipelined Kogge-Stone adder.
package ks_pkg;

   localparam int MAX_WIDTH = 64;

   typedef struct packed {
      logic g;
      logic p;
   } gp_t;

   function automatic int clog2(input int n);
      int r = 0;
      for (int i = 0; i < MAX_WIDTH; i++)
         if ((1 << r) < n) r++;
      return r;
   endfunction

   // Prefix level (1-based) after which register cut j sits.
   function automatic int cut_level(input int j, input int levels, input int pipe);
      return (j * levels + pipe) / (pipe + 1);
   endfunction

   // Cut number that follows level l, or 0 when level l is not registered.
   function automatic int cut_index(input int l, input int levels, input int pipe);
      int r = 0;
      for (int j = 1; j <= pipe; j++)
         if (cut_level(j, levels, pipe) == l) r = j;
      return r;
   endfunction

endpackage

// File: rtl/ks_adder_pipe_sum_cell.sv
// Final per-bit cell: resolves the group carry against c0 and forms the sum bit.
module ks_sum_cell (
   input  logic g,
   input  logic p_grp,
   input  logic c0,
   input  logic p_bit,
   input  logic c_prev,
   output logic c,
   output logic sum
);

   assign c   = g | (p_grp & c0);
   assign sum = p_bit ^ c_prev;

endmodule

// File: rtl/ks_adder_pipe.sv
// Pipelined Kogge-Stone add/subtract with valid/ready on both sides and
// PIPE register cuts spread evenly through the prefix tree.
module ks_adder_pipe
   import ks_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int PIPE  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);

   localparam int LEVELS = clog2(WIDTH);
   localparam int NST    = PIPE + 1;

   typedef struct packed {
      logic [WIDTH-1:0] p;
      logic             c0;
      logic             a_msb;
      logic             bi_msb;
   } side_t;

   logic [NST:1]   v;
   logic [NST:0]   vld_pipe;
   logic [NST+1:1] ld;
   logic [WIDTH-1:0] bi;

   assign vld_pipe = {v, in_valid};
   assign bi       = in_sub ? ~in_b : in_b;

   // Ready chain: a stage loads when empty or when its successor loads.
   always_comb begin
      ld = '0;
      ld[NST+1] = out_ready;
      for (int s = NST; s >= 1; s--)
         ld[s] = ~v[s] | ld[s+1];
   end

   assign in_ready  = ld[1];
   assign out_valid = v[NST];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) v <= '0;
      else
         for (int s = 1; s <= NST; s++)
            if (ld[s]) v[s] <= vld_pipe[s-1];
   end

   for (genvar l = 0; l <= LEVELS; l++) begin : g_lvl
      gp_t [WIDTH-1:0] gp;
      side_t           sd;
      if (l == 0) begin : g_in
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            assign gp[i] = '{g: in_a[i] & bi[i], p: in_a[i] ^ bi[i]};
         end
         assign sd = '{p: in_a ^ bi, c0: in_sub | in_cin,
                       a_msb: in_a[WIDTH-1], bi_msb: bi[WIDTH-1]};
      end else begin : g_pre
         localparam int SPAN = 1 << (l - 1);
         localparam int CI   = cut_index(l, LEVELS, PIPE);
         gp_t [WIDTH-1:0] nxt;
         for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if (i >= SPAN) begin : g_op
               assign nxt[i] = '{g: g_lvl[l-1].gp[i].g | (g_lvl[l-1].gp[i].p & g_lvl[l-1].gp[i-SPAN].g),
                                 p: g_lvl[l-1].gp[i].p & g_lvl[l-1].gp[i-SPAN].p};
            end else begin : g_pass
               assign nxt[i] = g_lvl[l-1].gp[i];
            end
         end
         if (CI == 0) begin : g_comb
            assign gp = nxt;
            assign sd = g_lvl[l-1].sd;
         end else begin : g_cut
            // Data only moves with a real beat, so a stalled cut keeps its contents.
            always_ff @(posedge clk or posedge rst) begin
               if (rst) begin
                  gp <= '0;
                  sd <= '0;
               end else if (ld[CI] & vld_pipe[CI-1]) begin
                  gp <= nxt;
                  sd <= g_lvl[l-1].sd;
               end
            end
         end
      end
   end

   gp_t [WIDTH-1:0]  fin;
   side_t            fsd;
   logic [WIDTH-1:0] carry;
   logic [WIDTH-1:0] sum;
   logic             ovf;

   assign fin = g_lvl[LEVELS].gp;
   assign fsd = g_lvl[LEVELS].sd;

   for (genvar i = 0; i < WIDTH; i++) begin : g_sum
      logic c_prev;
      if (i == 0) begin : g_lsb
         assign c_prev = fsd.c0;
      end else begin : g_up
         assign c_prev = carry[i-1];
      end
      ks_sum_cell u_cell (
         .g      (fin[i].g),
         .p_grp  (fin[i].p),
         .c0     (fsd.c0),
         .p_bit  (fsd.p[i]),
         .c_prev (c_prev),
         .c      (carry[i]),
         .sum    (sum[i])
      );
   end

   assign ovf = (fsd.a_msb == fsd.bi_msb) & (sum[WIDTH-1] != fsd.a_msb);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_sum  <= '0;
         out_cout <= 1'b0;
         out_ovf  <= 1'b0;
      end else if (ld[NST] & vld_pipe[NST-1]) begin
         out_sum  <= sum;
         out_cout <= carry[WIDTH-1];
         out_ovf  <= ovf;
      end
   end

endmodule

// File: tb/tb_ks_adder_pipe.sv
// Scoreboard bench for ks_adder_pipe: main 16-bit/PIPE=2 instance plus
// width/depth corner instances for the carry-in ripple vector.
module tb_ks_adder_pipe;

   localparam int W = 16;
   localparam int P = 2;

   typedef struct packed {
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } exp_t;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic         sub;
      exp_t         e;
   } vec_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [W-1:0] in_a = '0;
   logic [W-1:0] in_b = '0;
   logic         in_cin = 1'b0;
   logic         in_sub = 1'b0;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;

   logic        xv = 1'b0;
   logic        x2_ir, x2_ov, x2_co, x2_of;
   logic [1:0]  x2_s;
   logic        x5_ir, x5_ov, x5_co, x5_of;
   logic [4:0]  x5_s;
   logic        x64_ir, x64_ov, x64_co, x64_of;
   logic [63:0] x64_s;

   int   n_cmp = 0;
   int   n_err = 0;
   int   acc   = 0;
   exp_t q[$];
   exp_t cur_exp = '0;

   vec_t dir [6] = '{
      '{a: 16'h0003, b: 16'h0005, cin: 1'b0, sub: 1'b1, e: '{sum: 16'hFFFE, cout: 1'b0, ovf: 1'b0}},
      '{a: 16'h8000, b: 16'h0001, cin: 1'b0, sub: 1'b1, e: '{sum: 16'h7FFF, cout: 1'b1, ovf: 1'b1}},
      '{a: 16'h0005, b: 16'h0005, cin: 1'b1, sub: 1'b1, e: '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0}},
      '{a: 16'hFFFF, b: 16'h0000, cin: 1'b1, sub: 1'b0, e: '{sum: 16'h0000, cout: 1'b1, ovf: 1'b0}},
      '{a: 16'h8000, b: 16'h8000, cin: 1'b0, sub: 1'b0, e: '{sum: 16'h0000, cout: 1'b1, ovf: 1'b1}},
      '{a: 16'h1234, b: 16'h4321, cin: 1'b1, sub: 1'b0, e: '{sum: 16'h5556, cout: 1'b0, ovf: 1'b0}}
   };

   ks_adder_pipe #(.WIDTH(W), .PIPE(P)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
      .out_cout(out_cout), .out_ovf(out_ovf)
   );

   ks_adder_pipe #(.WIDTH(2), .PIPE(0)) u_x2 (
      .clk(clk), .rst(rst), .in_valid(xv), .in_ready(x2_ir),
      .in_a(2'b11), .in_b(2'b00), .in_cin(1'b1), .in_sub(1'b0),
      .out_valid(x2_ov), .out_ready(1'b1), .out_sum(x2_s),
      .out_cout(x2_co), .out_ovf(x2_of)
   );

   ks_adder_pipe #(.WIDTH(5), .PIPE(2)) u_x5 (
      .clk(clk), .rst(rst), .in_valid(xv), .in_ready(x5_ir),
      .in_a(5'h1F), .in_b(5'h00), .in_cin(1'b1), .in_sub(1'b0),
      .out_valid(x5_ov), .out_ready(1'b1), .out_sum(x5_s),
      .out_cout(x5_co), .out_ovf(x5_of)
   );

   ks_adder_pipe #(.WIDTH(64), .PIPE(5)) u_x64 (
      .clk(clk), .rst(rst), .in_valid(xv), .in_ready(x64_ir),
      .in_a({64{1'b1}}), .in_b(64'd0), .in_cin(1'b1), .in_sub(1'b0),
      .out_valid(x64_ov), .out_ready(1'b1), .out_sum(x64_s),
      .out_cout(x64_co), .out_ovf(x64_of)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub);
      logic [W-1:0] bi;
      logic [W:0]   f;
      exp_t         r;
      bi = sub ? ~b : b;
      f  = {1'b0, a} + {1'b0, bi} + {{W{1'b0}}, (sub ? 1'b1 : cin)};
      r.sum  = f[W-1:0];
      r.cout = f[W];
      r.ovf  = (a[W-1] == bi[W-1]) && (f[W-1] != a[W-1]);
      return r;
   endfunction

   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic cin, input logic sub, input exp_t e);
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_sub   = sub;
      cur_exp  = e;
      in_valid = 1'b1;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (q.size() != 0 && n < 200) begin
         step();
         n++;
      end
      if (q.size() != 0) begin
         n_cmp++;
         n_err++;
         $display("FAIL drain_timeout: %0d beats outstanding, expected 0", q.size());
      end
      step();
   endtask

   // Scoreboard push: a beat is taken iff in_valid & in_ready at the edge.
   always @(negedge clk) begin
      if (!rst && in_valid && in_ready) begin
         q.push_back(cur_exp);
         acc++;
      end
   end

   always @(negedge clk) begin : mon
      exp_t e;
      if (!rst && out_valid && out_ready) begin
         n_cmp++;
         if (q.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_out: got sum=0x%0h with no beat outstanding", out_sum);
         end else begin
            e = q.pop_front();
            if ({out_sum, out_cout, out_ovf} !== e) begin
               n_err++;
               $display("FAIL result: got sum=0x%0h cout=%0b ovf=%0b, expected sum=0x%0h cout=%0b ovf=%0b",
                        out_sum, out_cout, out_ovf, e.sum, e.cout, e.ovf);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int           cyc;
      int           a0;
      int           ghosts;
      logic         have;
      logic [W-1:0] held;
      logic [W-1:0] ra, rb;
      logic         rc, rs;
      int           l2, l5, l64;
      logic [1:0]   s2;
      logic [4:0]   s5;
      logic [63:0]  s64;
      logic         c2, c5, c64, o64;

      // Reset state
      #2;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_sum", out_sum, 0);
      chk("rst_out_cout", out_cout, 0);
      chk("rst_out_ovf", out_ovf, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("in_ready_post_reset", in_ready, 1);

      // Single beat latency
      drive(16'h7FFF, 16'h0001, 1'b0, 1'b0, '{sum: 16'h8000, cout: 1'b0, ovf: 1'b1});
      step();
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
         step();
         cyc++;
      end
      chk("latency_p2", cyc, P + 1);
      step();

      // Directed vectors back to back
      foreach (dir[i]) begin
         drive(dir[i].a, dir[i].b, dir[i].cin, dir[i].sub, dir[i].e);
         step();
      end
      in_valid = 1'b0;
      drain();

      // Streaming at full rate
      a0 = acc;
      for (int i = 0; i < 100; i++) begin
         ra = W'($urandom);
         rb = W'($urandom);
         rc = 1'($urandom);
         rs = 1'($urandom);
         drive(ra, rb, rc, rs, model(ra, rb, rc, rs));
         @(negedge clk);
         if (!in_ready) chk("stream_in_ready", in_ready, 1);
         step();
      end
      in_valid = 1'b0;
      chk("stream_accepted", acc - a0, 100);
      drain();

      // Backpressure
      out_ready = 1'b0;
      a0   = acc;
      have = 1'b0;
      held = '0;
      for (int i = 0; i < 7; i++) begin
         if (i < 5) begin
            ra = W'(i * 16'h1111 + 16'h0F0F);
            drive(ra, 16'h0101, 1'(i), 1'b0, model(ra, 16'h0101, 1'(i), 1'b0));
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (out_valid) begin
            if (!have) begin
               held = out_sum;
               have = 1'b1;
            end else begin
               chk("stall_sum_stable", out_sum, held);
            end
         end
         step();
         if (i == 4) begin
            chk("stall_accepted", acc - a0, P + 1);
            chk("stall_in_ready", in_ready, 0);
         end
      end
      out_ready = 1'b1;
      drain();

      // Carry-in ripple across widths and depths
      xv = 1'b1;
      l2 = 0; l5 = 0; l64 = 0;
      s2 = '0; s5 = '0; s64 = '0;
      c2 = 1'b0; c5 = 1'b0; c64 = 1'b0; o64 = 1'b1;
      for (int c = 1; c <= 10; c++) begin
         step();
         if (c == 1) xv = 1'b0;
         if (x2_ov && l2 == 0) begin l2 = c; s2 = x2_s; c2 = x2_co; end
         if (x5_ov && l5 == 0) begin l5 = c; s5 = x5_s; c5 = x5_co; end
         if (x64_ov && l64 == 0) begin l64 = c; s64 = x64_s; c64 = x64_co; o64 = x64_of; end
      end
      chk("w2_latency", l2, 1);
      chk("w2_sum", s2, 0);
      chk("w2_cout", c2, 1);
      chk("w5_latency", l5, 3);
      chk("w5_sum", s5, 0);
      chk("w5_cout", c5, 1);
      chk("w64_latency", l64, 6);
      chk("w64_sum", s64, 0);
      chk("w64_cout", c64, 1);
      chk("w64_ovf", o64, 0);

      // Asynchronous reset with beats in flight
      for (int i = 0; i < 3; i++) begin
         ra = W'(16'h0A00 + i);
         drive(ra, 16'h0011, 1'b0, 1'b0, model(ra, 16'h0011, 1'b0, 1'b0));
         step();
      end
      in_valid = 1'b0;
      #1;
      chk("pre_reset_out_valid", out_valid, 1);
      #1 rst = 1'b1;
      #1;
      chk("reset_out_valid", out_valid, 0);
      chk("reset_out_sum", out_sum, 0);
      q.delete();
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      chk("in_ready_after_flush", in_ready, 1);
      ghosts = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (out_valid) ghosts++;
      end
      chk("flushed_beats_emitted", ghosts, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/ks_adder_pipe.md
Name: ks_adder_pipe

Overview:
Parametrised, pipelined Kogge-Stone adder/subtractor with valid/ready handshakes on input and output. It is the next-generation, multi-cycle replacement for the single-bit sum stage in the arithmetic library. It adds configurable width, configurable prefix-tree pipelining, a subtract mode, signed overflow and backpressure. It sits between operand producers and result consumers in datapaths that need a full-throughput, one-result-per-cycle adder.

Parameters:
WIDTH, 32, operand/result width in bits; legal range 2..64.
PIPE, 1, number of register cuts inside the prefix tree; legal range 0..LEVELS-1, where LEVELS = clog2(WIDTH).
LEVELS, clog2(WIDTH), derived localparam; not overridable.

Ports:
clk  in  1  rising-edge clock
rst  in  1  reset, asynchronous, active-high; the only reset in the block
in_valid  in  1  operand beat valid
in_ready  out  1  block can accept a beat this cycle
in_a  in  WIDTH  operand A
in_b  in  WIDTH  operand B
in_cin  in  1  carry-in; ignored when in_sub=1
in_sub  in  1  1: result = A - B (B inverted, carry-in forced to 1); 0: result = A + B + cin
out_valid  out  1  result beat valid
out_ready  in  1  consumer accepts the result beat
out_sum  out  WIDTH  result, modulo 2^WIDTH
out_cout  out  1  carry out of the MSB (for subtract: 1 means no borrow)
out_ovf  out  1  signed two's-complement overflow

Behaviour:
- Stage 0 is combinational on the inputs:
  - bi = in_sub ? ~in_b : in_b
  - c0 = in_sub ? 1 : in_cin
  - g_i = a_i & bi_i, p_i = a_i ^ bi_i
- Prefix tree:
  - LEVELS Kogge-Stone levels, span 2^k at level k: (G,P)_i = (G_i | P_i & G_{i-2^k}, P_i & P_{i-2^k}).
  - c0 is folded in as position -1, i.e. G_{-1} = c0.
- Pipeline registers:
  - PIPE cuts, placed after level ceil(j*LEVELS/(PIPE+1)) for j = 1..PIPE.
  - Each cut registers the group (G,P) vectors, the original p vector, c0, a_msb and bi_msb.
- Sum stage:
  - sum_i = p_i ^ C_{i-1}, with C_{-1} = c0.
  - cout = C_{WIDTH-1}.
  - ovf = (a_msb == bi_msb) & (sum_msb != a_msb).
  - Result is registered into the output register.
- Latency: PIPE+1 cycles from accepted input beat to out_valid, with no stalls. Throughput is one beat per cycle.
- Handshake:
  - Every stage s (cuts plus output register) has a valid bit v_s.
  - Stage s loads when (~v_s | adv_{s+1}); for the output stage, adv_out = out_ready.
  - Bubbles collapse; a stage holds its data while stalled.
  - in_ready = ~v_first | adv_first. This is a combinational ready chain from out_ready.
  - An input beat is accepted iff in_valid & in_ready. Input values are don't-care when in_valid=0.
  - out_* hold stable while out_valid & ~out_ready (AXI-style).
  - out_valid never drops without a handshake.
- Simultaneous events: a stage that is full and draining loads the new upstream beat in the same cycle, so there is no dead cycle.
- Reset values, all registers: v_s=0, out_valid=0, out_sum=0, out_cout=0, out_ovf=0, data registers 0.
- Reset mid-operation: all in-flight beats are discarded and nothing is emitted for them. in_ready is 1 in the first cycle after reset deassertion.
- Width rules:
  - No saturation; sum wraps modulo 2^WIDTH.
  - cout and ovf are reported separately; both are valid for both modes.
- PIPE=0: a single registered stage, latency 1, in_ready = ~out_valid | out_ready.

Decomposition:
- Shared package ks_pkg:
  - function clog2
  - function cut_level(j, LEVELS, PIPE)
  - localparam MAX_WIDTH=64
  - typedef gp_t {G, P}
- One natural sub-module, ks_sum_cell. It is the per-bit final cell (inputs G, P, p_i, c_prev; outputs C, sum_i), instantiated WIDTH times in a generate loop.
- Prefix levels and pipeline cuts are generated inline in ks_adder_pipe.

Test Plan:
1. WIDTH=16, PIPE=2. Reset, then a=0x7FFF, b=0x0001, cin=0, sub=0, out_ready=1 -> 3 cycles later out_valid=1, sum=0x8000, cout=0, ovf=1.
2. WIDTH=16, sub=1, a=0x0003, b=0x0005 -> sum=0xFFFE, cout=0, ovf=0. Then a=0x8000, b=0x0001 -> sum=0x7FFF, cout=1, ovf=1.
3. Streaming: 100 random beats back-to-back, out_ready=1 -> in_ready stays 1, results arrive in order one per cycle, and each matches a reference model (A±B+cin mod 2^16, cout, ovf).
4. Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly PIPE+1=3 beats accepted, then in_ready=0. out_sum is stable throughout. On out_ready=1, all beats drain in order with no loss or duplication.
5. Carry-in ripple: a=0xFFFF, b=0x0000, cin=1 -> sum=0x0000, cout=1. Repeat for WIDTH=2, 5, 64 and PIPE=0 and PIPE=LEVELS-1; latencies are 1 and LEVELS.
6. Reset asserted asynchronously mid-stream with 2 beats in flight -> out_valid=0 and out_sum=0 immediately. The flushed beats never appear after release; in_ready=1 on the first post-reset cycle.
